dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_ram_array.sv | 29 ++
 rtl/dmem_responder.sv | 105 ++++++++++
 tb/tb_dmem_responder.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants for the M-stage data memory responder: FSM encoding, counter width, byte-lane masks.
// The misalignment helper is only referenced when DMEM_ALIGN_CHECK_EN is defined.
package dmem_pkg;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam int LAT_W = 4;

   localparam logic [3:0] SEL_WORD = 4'hF;
   localparam logic [3:0] SEL_HI   = 4'hC;
   localparam logic [3:0] SEL_LO   = 4'h3;

   // Word accesses need a word-aligned address, half-word lanes need an even address.
   function automatic logic misaligned(input logic [3:0] sel, input logic [1:0] off);
      return ((sel == SEL_WORD) && (off != 2'b00)) ||
             (((sel == SEL_HI) || (sel == SEL_LO)) && off[0]);
   endfunction
endpackage

// File: rtl/dmem_ram_array.sv
// Single-port 32-bit word RAM with per-byte write enables and a registered read port.
// Only the read register is reset; the storage array keeps its contents.
module dmem_ram_array #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [3:0]        we_i,
   input  logic              re_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o
);
   logic [31:0] mem_q [0:(1<<ADDR_W)-1];
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst)      rdata_q <= 32'h0;
      else if (re_i) rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/dmem_responder.sv
// M-stage data memory responder: latches a request, waits LATENCY cycles, then performs the access.
// Optional alignment checking and addr_err port are compiled in with DMEM_ALIGN_CHECK_EN.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_en,
   input  logic        req_we,
   input  logic [3:0]  req_sel,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic [31:0] rdata,
`ifdef DMEM_ALIGN_CHECK_EN
   output logic        addr_err,
`endif
   output logic        stall
);
   logic [1:0]        state_q, state_d;
   logic [LAT_W-1:0]  cnt_q, cnt_d;
   logic              we_q;
   logic [3:0]        sel_q;
   logic [ADDR_W-1:0] idx_q;
   logic [31:0]       wdata_q;
   logic              fire;
   logic              wr_ok;
   logic              unused_addr_bits;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fire    = 1'b0;
      case (state_q)
         IDLE: if (req_en) begin
            state_d = BUSY;
            cnt_d   = LAT_W'(LATENCY - 1);
         end
         BUSY: if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
         end else begin
            fire    = 1'b1;
            state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Request fields are captured only on acceptance; BUSY ignores input changes.
   always_ff @(posedge clk) begin
      if (state_q == IDLE && req_en) begin
         we_q    <= req_we;
         sel_q   <= req_sel;
         idx_q   <= req_addr[ADDR_W+1:2];
         wdata_q <= req_wdata;
      end
   end

`ifdef DMEM_ALIGN_CHECK_EN
   logic [1:0] off_q;
   logic       err_q;

   always_ff @(posedge clk) begin
      if (state_q == IDLE && req_en) off_q <= req_addr[1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst) err_q <= 1'b0;
      else      err_q <= fire && misaligned(sel_q, off_q);
   end

   assign wr_ok    = !misaligned(sel_q, off_q);
   assign addr_err = err_q;
`else
   assign wr_ok = 1'b1;
`endif

   assign unused_addr_bits = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};

   // Gating with rst keeps a reset during the final BUSY cycle from committing the store.
   dmem_ram_array #(.ADDR_W(ADDR_W)) u_ram (
      .clk     (clk),
      .rst     (rst),
      .addr_i  (idx_q),
      .we_i    ({4{fire & we_q & rst & wr_ok}} & sel_q),
      .re_i    (fire & ~we_q),
      .wdata_i (wdata_q),
      .rdata_o (rdata)
   );

   assign stall = rst & req_en & (state_q != RESP);
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a transaction-level memory model drives per-cycle expectations
// for stall/rdata (and addr_err when DMEM_ALIGN_CHECK_EN is defined), plus literal spot checks.
module tb_dmem_responder;
   localparam int AW  = 10;
   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_en, req_we;
   logic [3:0]  req_sel;
   logic [31:0] req_addr, req_wdata;
   logic [31:0] rdata;
   logic        stall;
`ifdef DMEM_ALIGN_CHECK_EN
   logic        addr_err;
`endif

   dmem_responder #(.ADDR_W(AW), .LATENCY(LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_en    (req_en),
      .req_we    (req_we),
      .req_sel   (req_sel),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rdata     (rdata),
`ifdef DMEM_ALIGN_CHECK_EN
      .addr_err  (addr_err),
`endif
      .stall     (stall)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [31:0] mem_m [0:(1<<AW)-1];
   logic        chk_en = 1'b0;
   logic        exp_stall;
   logic [31:0] exp_rdata;
   logic        exp_err = 1'b0;
   int          stall_hi;
   int          err_hi;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Mid-cycle compare of every output against the model's expectation.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("stall", {31'b0, stall}, {31'b0, exp_stall});
         chk("rdata", rdata, exp_rdata);
         if (stall === 1'b1) stall_hi++;
`ifdef DMEM_ALIGN_CHECK_EN
         chk("addr_err", {31'b0, addr_err}, {31'b0, exp_err});
         if (addr_err === 1'b1) err_hi++;
`endif
      end
   end

   task automatic step();
      @(posedge clk); #2;
   endtask

   function automatic logic bad_align(input logic [3:0] sel, input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
      if (sel == 4'b1111) return a[1:0] != 2'b00;
      if (sel == 4'b0011 || sel == 4'b1100) return a[0];
`endif
      return 1'b0;
   endfunction

   // One access starting in IDLE; returns just after the edge that re-enters IDLE.
   task automatic access(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                         input logic [31:0] wd, input logic flush);
      int idx;
      idx = int'(addr[AW+1:2]);
      stall_hi = 0;
      err_hi   = 0;
      req_en = 1'b1; req_we = we; req_sel = sel; req_addr = addr; req_wdata = wd;
      exp_stall = 1'b1;
      step();
      if (flush) begin req_en = 1'b0; exp_stall = 1'b0; end
      req_we = ~we; req_sel = ~sel; req_addr = addr ^ 32'h0000_0004; req_wdata = ~wd;
      for (int i = 0; i < LAT; i++) step();
      // Now in the response cycle: apply the access to the model.
      exp_stall = 1'b0;
      if (we) begin
         if (!bad_align(sel, addr))
            for (int b = 0; b < 4; b++) if (sel[b]) mem_m[idx][8*b +: 8] = wd[8*b +: 8];
      end else begin
         exp_rdata = mem_m[idx];
      end
      exp_err = bad_align(sel, addr);
      step();
      exp_err   = 1'b0;
      exp_stall = req_en;
      req_we = 1'b0; req_sel = 4'h0; req_addr = 32'h0; req_wdata = 32'h0;
   endtask

   initial begin
      rst = 1'b0; req_en = 1'b1; req_we = 1'b1; req_sel = 4'hF;
      req_addr = 32'h40; req_wdata = 32'h5555_5555;
      exp_stall = 1'b0; exp_rdata = 32'h0;
      step();
      chk_en = 1'b1;
      step(); step();

      rst = 1'b1;
      access(1'b1, 4'hF, 32'h40, 32'hDEADBEEF, 1'b0);
      chk("stall_cycles", stall_hi, 3);
      access(1'b0, 4'hF, 32'h40, 32'h0, 1'b0);
      chk("load_40", rdata, 32'hDEADBEEF);

      access(1'b1, 4'b0100, 32'h40, 32'h00AA0000, 1'b0);
      chk("store_keeps_rdata", rdata, 32'hDEADBEEF);
      access(1'b0, 4'h1, 32'h40, 32'h0, 1'b0);
      chk("byte_write", rdata, 32'hDEAABEEF);

      access(1'b1, 4'hF, 32'h0000_1010, 32'h12345678, 1'b0);
      access(1'b0, 4'hF, 32'h0000_0010, 32'h0, 1'b0);
      chk("alias", rdata, 32'h12345678);

      // Reset during the last BUSY cycle must abort the store.
      access(1'b1, 4'hF, 32'h80, 32'h0, 1'b0);
      req_en = 1'b1; req_we = 1'b1; req_sel = 4'hF; req_addr = 32'h80; req_wdata = 32'hFFFFFFFF;
      exp_stall = 1'b1;
      step(); step();
      rst = 1'b0; exp_stall = 1'b0;
      step();
      exp_rdata = 32'h0;
      rst = 1'b1; req_en = 1'b0;
      step();
      access(1'b0, 4'hF, 32'h80, 32'h0, 1'b0);
      chk("reset_abort", rdata, 32'h0);

      access(1'b1, 4'h0, 32'h40, 32'hFFFFFFFF, 1'b0);
      access(1'b0, 4'h0, 32'h40, 32'h0, 1'b0);
      chk("sel_zero", rdata, 32'hDEAABEEF);

      access(1'b1, 4'hF, 32'h44, 32'hCAFEF00D, 1'b1);
      chk("flush_stall_cycles", stall_hi, 1);
      access(1'b0, 4'hF, 32'h44, 32'h0, 1'b0);
      chk("flush_store", rdata, 32'hCAFEF00D);

`ifdef DMEM_ALIGN_CHECK_EN
      access(1'b1, 4'hF, 32'h40, 32'h11111111, 1'b0);
      chk("aligned_err", err_hi, 0);
      access(1'b1, 4'hF, 32'h42, 32'h22222222, 1'b0);
      chk("misaligned_err", err_hi, 1);
      access(1'b0, 4'hF, 32'h40, 32'h0, 1'b0);
      chk("misaligned_no_write", rdata, 32'h11111111);
      access(1'b0, 4'b1100, 32'h45, 32'h0, 1'b0);
      chk("misaligned_load", rdata, 32'hCAFEF00D);
      chk("misaligned_load_err", err_hi, 1);
`endif

      req_en = 1'b0; exp_stall = 1'b0;
      step(); step();
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
